// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 selector datapath.
// Bounded bursts, registered one-hot grant and select lines.
module mux4_rr_arbiter #(
    parameter int W         = 1,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] in,
    output logic [3:0]     gnt,
    output logic           s0,
    output logic           s1,
    output logic           valid,
    output logic [W-1:0]   y
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0] win;
    logic       any_req;
    logic       in_grant;
    logic       rel;
    logic       grant_now;
    logic       drop_now;
    logic       step_now;

    // Scan last+1 .. last+4; the lowest offset with a request wins.
    function automatic logic [1:0] winner(
        input logic [3:0] r,
        input logic [1:0] l
    );
        logic [1:0] idx;
        winner = l;
        for (int d = 4; d >= 1; d--) begin
            idx = l + 2'(d);
            if (r[idx]) winner = idx;
        end
    endfunction

    assign win      = winner(req, last_q);
    assign any_req  = |req;
    assign in_grant = (state_q == GRANT);
    assign valid    = in_grant && req[sel_q];
    assign rel      = in_grant && (!req[sel_q] || cnt_q == CNT_LAST);

    assign grant_now = (!in_grant || rel) && any_req;
    assign drop_now  = rel && !any_req;
    assign step_now  = valid && !rel;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            grant_now: begin
                state_d = GRANT;
                gnt_d   = 4'b0001 << win;
                sel_d   = win;
                last_d  = win;
                cnt_d   = '0;
            end
            drop_now: begin
                // select lines deliberately hold their last value
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
            step_now: begin
                cnt_d = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt = gnt_q;
    assign s0  = sel_q[1];
    assign s1  = sel_q[0];
    assign y   = valid ? in[sel_q*W +: W] : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: vector table, directed corners,
// and random traffic against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req4 = '0, in4 = '0;
    logic [3:0] req1 = '0, in1 = '0;
    logic [3:0] gnt4, gnt1;
    logic       s0_4, s1_4, valid4, y4;
    logic       s0_1, s1_1, valid1, y1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.W(1), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .in(in4),
        .gnt(gnt4), .s0(s0_4), .s1(s1_4), .valid(valid4), .y(y4)
    );

    mux4_rr_arbiter #(.W(1), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .in(in1),
        .gnt(gnt1), .s0(s0_1), .s1(s1_1), .valid(valid1), .y(y1)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] in;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       y;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check4(input string nm, input logic [3:0] eg,
                          input logic [1:0] es, input logic ev,
                          input logic ey);
        chk({nm, "_gnt"}, 32'(gnt4), 32'(eg));
        chk({nm, "_sel"}, 32'({s0_4, s1_4}), 32'(es));
        chk({nm, "_valid"}, 32'(valid4), 32'(ev));
        chk({nm, "_y"}, 32'(y4), 32'(ey));
    endtask

    task automatic drive4(input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        req4 = r;
        in4  = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req4 = '0;
        req1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: owner -1 means idle; beats counts beats taken.
    int own[2], bts[2], lst[2], sl[2];
    int mb[2] = '{4, 1};

    function automatic int rr_winner(input logic [3:0] r, input int l);
        for (int d = 1; d <= 4; d++)
            if (r[(l + d) % 4]) return (l + d) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = -1;
            bts[k] = 0;
            lst[k] = 3;
            sl[k]  = 0;
        end
    endtask

    task automatic model_edge(input int k, input logic [3:0] r);
        bit rel;
        rel = 1'b1;
        if (own[k] >= 0 && r[own[k]]) begin
            bts[k]++;
            rel = (bts[k] == mb[k]);
        end
        if (rel) begin
            if (r != 4'b0000) begin
                own[k] = rr_winner(r, lst[k]);
                sl[k]  = own[k];
                lst[k] = own[k];
                bts[k] = 0;
            end else begin
                own[k] = -1;
            end
        end
    endtask

    task automatic model_check(input int k, input logic [3:0] r,
                               input logic [3:0] d, input logic [3:0] g,
                               input logic [1:0] s, input logic v,
                               input logic yy);
        logic [3:0] eg;
        logic       ev, ey;
        eg = (own[k] >= 0) ? 4'(1 << own[k]) : 4'b0000;
        ev = (own[k] >= 0) && r[own[k]];
        ey = ev ? d[own[k]] : 1'b0;
        chk($sformatf("rnd%0d_gnt", k), 32'(g), 32'(eg));
        chk($sformatf("rnd%0d_sel", k), 32'(s), 32'(sl[k]));
        chk($sformatf("rnd%0d_valid", k), 32'(v), 32'(ev));
        chk($sformatf("rnd%0d_y", k), 32'(yy), 32'(ey));
    endtask

    initial begin
        logic [3:0] lanes;
        logic [3:0] m;

        // idle rows, then req=1111 with in=1011 for five bursts
        for (int i = 0; i < 5; i++)
            tbl[i] = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        lanes = 4'b1011;
        tbl[5] = '{4'b1111, lanes, 4'b0000, 2'd0, 1'b0, 1'b0};
        for (int j = 0; j < 4; j++)
            for (int b = 0; b < 4; b++)
                tbl[6 + 4*j + b] = '{4'b1111, lanes, 4'(1 << j),
                                     2'(j), 1'b1, lanes[j]};
        tbl[22] = '{4'b1111, lanes, 4'b0001, 2'd0, 1'b1, lanes[0]};

        #1;
        check4("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive4(tbl[i].req, tbl[i].in);
            check4($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].sel,
                   tbl[i].valid, tbl[i].y);
        end

        // sole requester re-granted with no gap
        do_reset();
        drive4(4'b0001, 4'b0001);
        check4("solo0", 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            drive4(4'b0001, 4'b0001);
            check4($sformatf("solo%0d", i), 4'b0001, 2'd0, 1'b1, 1'b1);
        end

        // early drop by requester0, then full burst for requester2
        do_reset();
        drive4(4'b0101, 4'b0100);
        check4("drop0", 4'b0000, 2'd0, 1'b0, 1'b0);
        drive4(4'b0101, 4'b0100);
        check4("drop1", 4'b0001, 2'd0, 1'b1, 1'b0);
        drive4(4'b0101, 4'b0100);
        check4("drop2", 4'b0001, 2'd0, 1'b1, 1'b0);
        drive4(4'b0100, 4'b0100);
        check4("drop3", 4'b0001, 2'd0, 1'b0, 1'b0);
        drive4(4'b0100, 4'b0100);
        check4("drop4", 4'b0100, 2'd2, 1'b1, 1'b1);
        for (int i = 5; i < 8; i++) begin
            drive4(4'b0101, 4'b0100);
            check4($sformatf("drop%0d", i), 4'b0100, 2'd2, 1'b1, 1'b1);
        end
        drive4(4'b0101, 4'b0100);
        check4("drop8", 4'b0001, 2'd0, 1'b1, 1'b0);

        // release to idle, select holds, then new request from 3
        do_reset();
        drive4(4'b0100, 4'b1100);
        drive4(4'b0100, 4'b1100);
        check4("idle1", 4'b0100, 2'd2, 1'b1, 1'b1);
        drive4(4'b0000, 4'b1100);
        check4("idle2", 4'b0100, 2'd2, 1'b0, 1'b0);
        drive4(4'b1000, 4'b1100);
        check4("idle3", 4'b0000, 2'd2, 1'b0, 1'b0);
        drive4(4'b1000, 4'b1100);
        check4("idle4", 4'b1000, 2'd3, 1'b1, 1'b1);

        // asynchronous reset mid-burst, restart from requester0
        rst_n = 1'b0;
        #1;
        check4("arst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req4 = 4'b1001;
        #1;
        check4("arst_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        drive4(4'b1001, 4'b1001);
        check4("arst_regrant", 4'b0001, 2'd0, 1'b1, 1'b1);

        // single-beat bursts alternate between 1 and 2
        do_reset();
        @(negedge clk);
        req1 = 4'b0110;
        in1  = 4'b0010;
        #1;
        chk("mb1_gnt0", 32'(gnt1), 32'h0);
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mb1_gnt%0d", i), 32'(gnt1),
                (i % 2) ? 32'h2 : 32'h4);
            chk($sformatf("mb1_valid%0d", i), 32'(valid1), 32'h1);
            chk($sformatf("mb1_y%0d", i), 32'(y1), (i % 2) ? 32'h1 : 32'h0);
        end

        // random traffic on both instances against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            m = 4'($urandom & $urandom);
            req4 = req4 ^ m;
            m = 4'($urandom & $urandom);
            req1 = req1 ^ m;
            in4 = 4'($urandom);
            in1 = 4'($urandom);
            #1;
            model_check(0, req4, in4, gnt4, {s0_4, s1_4}, valid4, y4);
            model_check(1, req1, in1, gnt1, {s0_1, s1_1}, valid1, y1);
            model_edge(0, req4);
            model_edge(1, req1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
